// File: rtl/tx_iq_fifo.sv
// tx_iq_fifo: first-word-fall-through TX IQ FIFO with prefill gating and
// sticky overflow/underrun status.
module tx_iq_fifo #(
   parameter int AW        = 10,
   parameter int PREFILL   = 512,
   parameter int AF_MARGIN = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   wr_data,
   input  logic          wr_en,
   output logic [31:0]   rd_data,
   output logic          rd_empty,
   input  logic          rd_strobe,
   input  logic          flush,
   input  logic          clear_flags,
   output logic [AW:0]   level,
   output logic          almost_full,
   output logic          overflow,
   output logic          underrun,
   output logic          streaming
);
   localparam int DEPTH = 2**AW;
   localparam logic [AW:0] L_DEPTH   = (AW+1)'(DEPTH);
   localparam logic [AW:0] L_PREFILL = (AW+1)'(PREFILL);
   localparam logic [AW:0] L_AF      = (AW+1)'(DEPTH - AF_MARGIN);

   typedef enum logic {PRIME, STREAM} state_t;

   state_t          r_state, w_state_nxt;
   logic [31:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [AW:0]     r_level, w_level_nxt;
   logic            r_ovf, r_unr;
   logic            w_pop, w_wr, w_ovf_evt, w_unr_evt;

   assign rd_empty    = (r_state == PRIME) || (r_level == '0);
   assign rd_data     = r_mem[r_rd_ptr];
   assign level       = r_level;
   assign almost_full = r_level >= L_AF;
   assign overflow    = r_ovf;
   assign underrun    = r_unr;
   assign streaming   = r_state == STREAM;

   // A same-cycle pop frees a slot, so a write at full is still accepted.
   assign w_pop       = rd_strobe && !rd_empty;
   assign w_wr        = wr_en && (r_level != L_DEPTH || w_pop);
   assign w_level_nxt = r_level + (AW+1)'(w_wr) - (AW+1)'(w_pop);
   assign w_ovf_evt   = !flush && wr_en && !w_wr;
   assign w_unr_evt   = !flush && r_state == STREAM && w_pop && w_level_nxt == '0;

   always_comb begin
      w_state_nxt = r_state;
      if (flush)
         w_state_nxt = PRIME;
      else if (r_state == PRIME)
         w_state_nxt = (w_level_nxt >= L_PREFILL) ? STREAM : PRIME;
      else
         w_state_nxt = w_unr_evt ? PRIME : STREAM;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= PRIME;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_ovf    <= 1'b0;
         r_unr    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_wr_ptr <= flush ? '0 : r_wr_ptr + AW'(w_wr);
         r_rd_ptr <= flush ? '0 : r_rd_ptr + AW'(w_pop);
         r_level  <= flush ? '0 : w_level_nxt;
         r_ovf    <= w_ovf_evt || (r_ovf && !clear_flags);
         r_unr    <= w_unr_evt || (r_unr && !clear_flags);
      end
   end

   always_ff @(posedge clk)
      if (w_wr && !flush) r_mem[r_wr_ptr] <= wr_data;
endmodule

// File: doc/tx_iq_fifo.md
Name: tx_iq_fifo

Overview:
- Single-clock, first-word-fall-through FIFO for 32-bit TX IQ words, format {Q[31:16], I[15:0]}.
- Sits directly upstream of the transmitter. The host-side word assembler writes into it; the transmitter's 48 kHz read strobe pops from it.
- Holds off the consumer until a prefill level is reached, which absorbs host jitter.
- Reports fill level, almost-full, overflow and underrun to the control/status path.

Parameters:
- AW, 10, address width; DEPTH = 2**AW = 1024 words.
- PREFILL, 512, words required before read-side empty deasserts after reset, flush or underrun; legal range 1..DEPTH.
- AF_MARGIN, 16, almost_full asserts when level >= DEPTH-AF_MARGIN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; all state cleared immediately.
- wr_data  in  32  IQ word from the host assembler.
- wr_en  in  1  write request, one word per cycle.
- rd_data  out  32  head word; valid whenever rd_empty=0. Connects to the transmitter's afTxFIFO.
- rd_empty  out  1  no word available to the consumer. Connects to afTxFIFOEmpty.
- rd_strobe  in  1  pop head word this cycle. Connects to afTxFIFOReadStrobe.
- flush  in  1  synchronous flush, e.g. on a PTT falling edge.
- clear_flags  in  1  clears the sticky overflow and underrun flags.
- level  out  AW+1  stored word count, 0..DEPTH.
- almost_full  out  1  level >= DEPTH-AF_MARGIN.
- overflow  out  1  sticky: a write was attempted while full.
- underrun  out  1  sticky: the FIFO drained while streaming.
- streaming  out  1  1 when the state machine is in STREAM.

Behaviour:
- Reset (async): wr_ptr=rd_ptr=0, level=0, state=PRIME, overflow=underrun=0. Outputs: rd_empty=1, almost_full=0, streaming=0. rd_data is don't-care. Memory is not cleared.
- Storage: DEPTH x 32 array with AW-bit pointers. Pointers wrap from DEPTH-1 to 0. level is tracked as an explicit counter.
- Write: if wr_en and level<DEPTH, store mem[wr_ptr]<=wr_data and increment wr_ptr. If wr_en and level==DEPTH, drop the word, leave the pointers unchanged, and set overflow the next cycle.
- Read: the pop is effective only if rd_strobe=1 and rd_empty=0. It increments rd_ptr. rd_strobe while rd_empty=1 is ignored with no side effect.
- FWFT: rd_data always shows mem[rd_ptr].
  - A word written at edge N is visible on rd_data, and may be popped, from cycle N+1 (only once streaming permits).
  - After a pop at edge N, the next word appears from cycle N+1.
- Simultaneous write and pop: both take effect and level is unchanged. This applies when full too: the pop frees a slot the same edge, so the write is accepted and overflow is not set.
- Level update: level += (write accepted) - (pop effective). almost_full is derived combinationally from the registered level.
- State machine:
  - PRIME: rd_empty=1 regardless of level. Go to STREAM at the edge where the next level >= PREFILL.
  - STREAM: rd_empty = (level==0). When a pop takes level to 0 with no concurrent write, set underrun and return to PRIME on that edge.
  - Any state, flush=1: go to PRIME.
- Flush: synchronous and highest priority. Same cycle, pointers and level go to 0 and state goes to PRIME. Any concurrent write or pop is discarded. Sticky flags are unaffected.
- clear_flags: clears overflow and underrun on the next edge. If a new overflow or underrun event occurs in the same cycle, the set wins.
- Latency: wr_en to possible pop is at least 1 cycle, plus the PREFILL gating.
- The transmitter's latch-on-strobe timing is satisfied: rd_data is stable in the strobe cycle.

Test Plan:
- Reset mid-traffic: assert reset asynchronously between edges while level=300 -> level=0, rd_empty=1, streaming=0, flags=0 immediately, without waiting for a clock edge.
- Prefill gating: write 511 words -> rd_empty stays 1. 512th write -> streaming=1 and rd_empty=0 the next cycle; rd_data equals the first word written (0x0001_0000).
- Ordering and wrap: stream 3000 incrementing words with interleaved pops at 1-in-3 cadence -> output sequence identical to input, pointers wrap correctly, no flags set.
- Full/overflow: fill 1024 words with no pops -> almost_full at level 1008. 1025th write dropped: level=1024, overflow=1. Write+pop in the same cycle at full -> accepted, overflow not set again after clear_flags.
- Underrun: stream state, pop until level=0 -> underrun=1, streaming=0, rd_empty=1. Strobes with rd_empty=1 -> no level change. Refill to 512 -> streaming resumes.
- Flush priority: flush with wr_en and rd_strobe both high at level=600 -> level=0, state PRIME, written word discarded, overflow/underrun unchanged.
